// File: rtl/reu_dma_engine.sv
// Purpose : REU DMA sequencer with C64-address, REU-address and length counters for all four transfer types.
// Latency : one byte per PHI2 falling edge (swap needs two); C64->REU adds one FLUSH edge for the last SDRAM write.
// Backpressure: BA=0 freezes every register and output in XFER/SWAPW; FLUSH completes regardless of BA.
//
// Ports: PHI2 (clock, falling edge), nRESET (sync active-low), BA, Execute, XferType, FixC64, FixREU,
//        Autoload, CA_Start/REUA_Start/Len_Start (register-file start values), Equal (verify result)
//        -> DMA, DMARW, RAMRD, RAMWR strobes, CA/REUA/Len counters, EndOfBlock/VerifyErr sticky flags,
//        XferDone one-edge pulse when DMA falls.
module reu_dma_engine #(
    parameter int C64A_W = 16,
    parameter int REUA_W = 24,
    parameter int LEN_W  = 16
) (
    input  logic              PHI2,
    input  logic              nRESET,
    input  logic              BA,
    input  logic              Execute,
    input  logic [1:0]        XferType,
    input  logic              FixC64,
    input  logic              FixREU,
    input  logic              Autoload,
    input  logic [C64A_W-1:0] CA_Start,
    input  logic [REUA_W-1:0] REUA_Start,
    input  logic [LEN_W-1:0]  Len_Start,
    input  logic              Equal,
    output logic              DMA,
    output logic              DMARW,
    output logic              RAMRD,
    output logic              RAMWR,
    output logic [C64A_W-1:0] CA,
    output logic [REUA_W-1:0] REUA,
    output logic [LEN_W-1:0]  Len,
    output logic              EndOfBlock,
    output logic              VerifyErr,
    output logic              XferDone
);

    typedef enum logic [1:0] {IDLE, XFER, SWAPW, FLUSH} state_t;

    localparam logic [1:0] T_C64_TO_REU = 2'b00;
    localparam logic [1:0] T_REU_TO_C64 = 2'b01;
    localparam logic [1:0] T_SWAP       = 2'b10;
    localparam logic [1:0] T_VERIFY     = 2'b11;

    state_t            state;
    logic [1:0]        xferType;   // latched at Execute so a register-file rewrite cannot change a running transfer
    logic [C64A_W-1:0] caInc;
    logic [REUA_W-1:0] reuaInc;
    logic              lenLast;
    logic              byteAdvance;
    logic              mismatch;
    logic              endXfer;

    assign caInc   = FixC64 ? CA : CA + C64A_W'(1);
    assign reuaInc = FixREU ? REUA : REUA + REUA_W'(1);
    // Len_Start==0 loads 0, which decrements to all-ones: that is the 2^LEN_W byte case for free.
    assign lenLast = (Len == LEN_W'(1));

    // Byte completions for every type except C64->REU, which has its own write-behind pipeline.
    assign byteAdvance = BA && (((state == XFER) && ((xferType == T_REU_TO_C64) || (xferType == T_VERIFY)))
                                || (state == SWAPW));
    // Equal refers to the byte read during the cycle that ends on this edge.
    assign mismatch    = BA && (state == XFER) && (xferType == T_VERIFY) && !Equal;
    assign endXfer     = byteAdvance && (lenLast || mismatch);

    always_ff @(negedge PHI2) begin
        XferDone <= 1'b0;
        if (!nRESET) begin
            state      <= IDLE;
            xferType   <= T_C64_TO_REU;
            DMA        <= 1'b0;
            DMARW      <= 1'b0;
            RAMRD      <= 1'b0;
            RAMWR      <= 1'b0;
            CA         <= '0;
            REUA       <= '0;
            Len        <= '1;
            EndOfBlock <= 1'b0;
            VerifyErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Execute) begin
                        CA         <= CA_Start;
                        REUA       <= REUA_Start;
                        Len        <= Len_Start;
                        EndOfBlock <= 1'b0;
                        VerifyErr  <= 1'b0;
                        xferType   <= XferType;
                        DMA        <= 1'b1;
                        DMARW      <= (XferType != T_REU_TO_C64);
                        RAMRD      <= (XferType != T_C64_TO_REU);
                        RAMWR      <= 1'b0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (BA && (xferType == T_SWAP)) begin
                        DMARW <= 1'b0;
                        RAMRD <= 1'b0;
                        RAMWR <= 1'b1;
                        state <= SWAPW;
                    end else if (BA && (xferType == T_C64_TO_REU)) begin
                        // The byte read last cycle is written to SDRAM this cycle; REUA follows the writes.
                        CA    <= caInc;
                        RAMWR <= 1'b1;
                        if (RAMWR) begin
                            REUA <= reuaInc;
                        end
                        if (lenLast) begin
                            EndOfBlock <= 1'b1;
                            DMA        <= 1'b0;
                            DMARW      <= 1'b0;
                            XferDone   <= 1'b1;
                            state      <= FLUSH;
                        end else begin
                            Len <= Len - LEN_W'(1);
                        end
                    end
                end
                SWAPW: begin
                    if (BA && !endXfer) begin
                        DMARW <= 1'b1;
                        RAMRD <= 1'b1;
                        RAMWR <= 1'b0;
                        state <= XFER;
                    end
                end
                FLUSH: begin
                    // Final SDRAM write retires; autoload waits until REUA has no pending advance.
                    RAMWR <= 1'b0;
                    state <= IDLE;
                    REUA  <= reuaInc;
                    if (Autoload) begin
                        CA   <= CA_Start;
                        REUA <= REUA_Start;
                        Len  <= Len_Start;
                    end
                end
                default: state <= IDLE;
            endcase

            if (byteAdvance) begin
                // On a mismatch the addresses still step past the failing byte, but Len keeps counting it.
                CA   <= caInc;
                REUA <= reuaInc;
                if (!endXfer) begin
                    Len <= Len - LEN_W'(1);
                end
                if (lenLast) begin
                    EndOfBlock <= 1'b1;
                end
                if (mismatch) begin
                    VerifyErr <= 1'b1;
                end
            end

            if (endXfer) begin
                DMA      <= 1'b0;
                DMARW    <= 1'b0;
                RAMRD    <= 1'b0;
                RAMWR    <= 1'b0;
                XferDone <= 1'b1;
                state    <= IDLE;
                if (Autoload) begin
                    CA   <= CA_Start;
                    REUA <= REUA_Start;
                    Len  <= Len_Start;
                end
            end
        end
    end

endmodule
